// File: rtl/c499_kc_pkg.sv
// Shared widths, FSM encoding and LFSR helpers for the c499 key checker.
package c499_kc_pkg;

   localparam int IN_W  = 41;
   localparam int OUT_W = 32;
   localparam int KEY_W = 31;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      APPLY   = 3'd1,
      SETTLE  = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } kc_state_t;

   // Fibonacci taps 41/38 in zero-based bit positions
   localparam int LFSR_TAP_HI = 40;
   localparam int LFSR_TAP_LO = 37;

   function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] x);
      return {x[IN_W-2:0], x[LFSR_TAP_HI] ^ x[LFSR_TAP_LO]};
   endfunction

   // The all-zero state is a lock-up point, so a zero seed is promoted to 1
   function automatic logic [IN_W-1:0] seed_fix(input logic [IN_W-1:0] s);
      return (s == '0) ? IN_W'(1) : s;
   endfunction

endpackage

// File: rtl/c499_lfsr41.sv
// 41-bit maximal-length Fibonacci LFSR with synchronous load and step enable.
module c499_lfsr41
   import c499_kc_pkg::*;
#(
   parameter logic [IN_W-1:0] RST_SEED = 41'h1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [IN_W-1:0] seed,
   input  logic            advance,
   output logic [IN_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= seed_fix(RST_SEED);
      else if (load)
         q <= seed_fix(seed);
      else if (advance)
         q <= lfsr_next(q);
   end

endmodule

// File: rtl/c499_key_checker.sv
// Drives a locked and a golden c499 with a repeatable LFSR pattern stream and
// scores the candidate key by counting output mismatches.
module c499_key_checker
   import c499_kc_pkg::*;
#(
   parameter int              N_PATTERNS    = 1024,
   parameter int              SETTLE_CYCLES = 1,
   parameter logic [IN_W-1:0] SEED          = 41'h1,
   parameter bit              STOP_ON_FAIL  = 1'b0,
   parameter int              ERR_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [KEY_W-1:0]  key_in,
   output logic [KEY_W-1:0]  key_out,
   output logic [IN_W-1:0]   pattern,
   input  logic [OUT_W-1:0]  locked_out,
   input  logic [OUT_W-1:0]  oracle_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [IN_W-1:0]   first_fail,
   output logic [15:0]       first_fail_idx
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   kc_state_t       state;
   logic [15:0]     pat_idx;
   logic [SC_W-1:0] settle_cnt;
   logic [IN_W-1:0] lfsr_q;
   logic            accept;
   logic            step;
   logic            mism;
   logic            last_pat;

   assign accept   = (state == IDLE) && start && !abort;
   assign step     = (state == COMPARE) && !abort;
   assign mism     = (locked_out != oracle_out);
   assign last_pat = (pat_idx == 16'(N_PATTERNS - 1));

   c499_lfsr41 #(
      .RST_SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .seed    (SEED),
      .advance (step),
      .q       (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         key_out        <= '0;
         pattern        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_fail     <= '0;
         first_fail_idx <= '0;
         pat_idx        <= '0;
         settle_cnt     <= '0;
      end else begin
         done <= 1'b0;
         // abort outranks every transition, including COMPARE->DONE
         if (abort && busy) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (accept) begin
                     key_out        <= key_in;
                     pat_idx        <= '0;
                     err_cnt        <= '0;
                     first_fail     <= '0;
                     first_fail_idx <= '0;
                     pass           <= 1'b0;
                     busy           <= 1'b1;
                     state          <= APPLY;
                  end
               end
               APPLY: begin
                  pattern    <= lfsr_q;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
               SETTLE: begin
                  if (settle_cnt == SC_W'(SETTLE_CYCLES - 1))
                     state <= COMPARE;
                  else
                     settle_cnt <= settle_cnt + SC_W'(1);
               end
               COMPARE: begin
                  if (mism) begin
                     // err_cnt saturates, so zero reliably marks "no mismatch yet"
                     if (err_cnt == '0) begin
                        first_fail     <= pattern;
                        first_fail_idx <= pat_idx;
                     end
                     if (err_cnt != '1)
                        err_cnt <= err_cnt + ERR_W'(1);
                  end
                  if (last_pat || (STOP_ON_FAIL && mism)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     pat_idx <= pat_idx + 16'd1;
                     state   <= APPLY;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  pass  <= (err_cnt == '0);
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/c499_key_checker.md
Name: c499_key_checker

Overview:
- Sequencer that drives one key-locked c499 instance and one unlocked golden c499 (oracle) with the same stream of pseudo-random 41-bit patterns.
- Compares their 32-bit outputs for each pattern and reports the mismatch count, the first failing pattern and a pass/fail verdict for the candidate key.
- Sits between a key-search or host controller (start/done handshake) and the two combinational c499 netlists.
- Replaces free-running $random stimulus with a deterministic, synthesizable, repeatable schedule.

Parameters:
- N_PATTERNS, 1024: patterns applied per run. Legal range is 1..65535.
- SETTLE_CYCLES, 1: cycles between driving a pattern and sampling the outputs. Must be at least 1.
- SEED, 41'h1: LFSR start value. A seed of 0 is replaced by 1.
- STOP_ON_FAIL, 0: when 1, the run ends at the first mismatch.
- ERR_W, 16: width of the mismatch counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run. Sampled only in IDLE.
- abort  in  1  end the run immediately, without a done pulse
- key_in  in  31  candidate key. Latched when start is accepted.
- key_out  out  31  latched key, driven to the locked c499 key pins
- pattern  out  41  stimulus, driven to both c499 instances (in[0..40])
- locked_out  in  32  outputs of the locked instance
- oracle_out  in  32  outputs of the golden instance
- busy  out  1  high from start acceptance until DONE or abort
- done  out  1  one-cycle pulse at the end of a run
- pass  out  1  err_cnt==0 for the last completed run
- err_cnt  out  ERR_W  mismatch count, saturating
- first_fail  out  41  pattern that produced the first mismatch
- first_fail_idx  out  16  index of that pattern

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the LFSR holds SEED (1 if SEED==0).
- FSM states: IDLE, APPLY, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 latches key_in into key_out, loads the LFSR with the seed, clears pat_idx, err_cnt, first_fail, first_fail_idx and pass, sets busy=1, and moves to APPLY.
- APPLY (1 cycle):
  - pattern <= lfsr.
  - settle counter <= 0.
  - Next state is SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - Next state is COMPARE.
- COMPARE (1 cycle):
  - If locked_out != oracle_out, err_cnt increments, saturating at 2^ERR_W-1.
  - On the first mismatch of the run, first_fail <= pattern and first_fail_idx <= pat_idx.
  - The LFSR advances: lfsr <= {lfsr[39:0], lfsr[40]^lfsr[37]}.
  - If pat_idx==N_PATTERNS-1, or STOP_ON_FAIL and a mismatch occurred, next state is DONE. Otherwise pat_idx increments and next state is APPLY.
- DONE (1 cycle):
  - done=1, busy <= 0, pass <= (err_cnt==0, including this cycle's update).
  - Next state is IDLE.
- Latency: with start accepted at edge 0, done is high during cycle 1 + N_PATTERNS*(SETTLE_CYCLES+2) when the run completes without early stop.
- Results: err_cnt, first_fail, first_fail_idx, pass and key_out are held until the next accepted start.
- Start handling: start is ignored while busy. start and abort together in IDLE: abort wins and the start is ignored.
- abort, when busy:
  - Next state is IDLE, busy <= 0, no done pulse.
  - pass <= 0; err_cnt and first_fail keep partial values.
  - abort has priority over a COMPARE→DONE transition in the same cycle.
- rst mid-run: returns all outputs to reset values on the next edge, with no done pulse.
- pattern is held stable through SETTLE and COMPARE. It changes only in APPLY.
- LFSR: 41-bit Fibonacci, taps 41/38, maximal length. The all-zero state never occurs.

Decomposition:
- Package c499_kc_pkg:
  - IN_W=41, OUT_W=32, KEY_W=31.
  - FSM state enum.
  - LFSR tap constants and a next-state function.
- Sub-module c499_lfsr41 with ports clk, rst, load, seed, advance, q.
- The checker instantiates one c499_lfsr41. The c499 netlists stay outside and are wired in the test bench or the top level.

Test Plan:
- Key-equivalent run: oracle_out tied to locked_out, N_PATTERNS=8, SETTLE_CYCLES=1 -> done in cycle 25, pass=1, err_cnt=0; pattern sequence matches the LFSR model from seed 1.
- Injected mismatch: the bench flips locked_out[5] only when pat_idx==3, N=8 -> err_cnt=1, first_fail_idx=3, first_fail equals the 4th LFSR value, pass=0.
- STOP_ON_FAIL=1 with a mismatch at idx 2, SETTLE_CYCLES=2 -> done in cycle 1+3*4=13, err_cnt=1, busy low the following cycle.
- Abort in SETTLE of pattern 5 -> no done, busy=0 the next cycle, pass=0, state IDLE. A new start then restarts from SEED with err_cnt=0.
- start pulsed while busy, and a key_in change mid-run -> no effect; key_out keeps the first key and done fires on the original schedule.
- rst asserted in COMPARE with a pending mismatch -> all outputs 0 next cycle; SEED=0 instance -> first pattern is 41'h1.
